// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: Execute-stage connection between the pipeline and the
// multiply/divide unit. The master is the pipeline side, which drives the
// request and the read select. The slave is the unit, which returns busy,
// the committed HI/LO registers and the selected read value.
interface mdu_hilo_if;
    logic        start;
    logic [4:0]  mlu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  mlu_out;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mlu_res;

    modport master (
        output start, mlu_op, A, B, mlu_out,
        input  busy, HI, LO, mlu_res
    );

    modport slave (
        input  start, mlu_op, A, B, mlu_out,
        output busy, HI, LO, mlu_res
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit with the architectural HI/LO registers.
// The result is computed when the operation starts and held in pending
// registers. A busy counter then models the multi-cycle latency, and the
// pending value is committed to HI/LO when the counter expires.
// Optional build macro MDU_MADD_EN adds madd/maddu/msub/msubu (ops 7..10),
// which accumulate into the committed {HI,LO}.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MTHI  = 5'd5;
    localparam logic [4:0] OP_MTLO  = 5'd6;
`ifdef MDU_MADD_EN
    localparam logic [4:0] OP_MADD  = 5'd7;
    localparam logic [4:0] OP_MADDU = 5'd8;
    localparam logic [4:0] OP_MSUB  = 5'd9;
    localparam logic [4:0] OP_MSUBU = 5'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_ok_q, pend_ok_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Products and sign-magnitude division of the current operands. Division
    // by magnitudes keeps 0x80000000 / -1 well defined, and a zero divisor is
    // replaced by 1 because that result is discarded anyway.
    always_comb begin
        prod_s     = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u     = {32'd0, bus.A} * {32'd0, bus.B};
        div_signed = (bus.mlu_op == OP_DIV);
        a_neg      = div_signed & bus.A[31];
        b_neg      = div_signed & bus.B[31];
        a_mag      = a_neg ? (32'd0 - bus.A) : bus.A;
        b_mag      = b_neg ? (32'd0 - bus.B) : bus.B;
        divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;
        quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state logic. A new operation is accepted only while idle. While
    // running, the counter decrements, and the final 1->0 step commits the
    // pending result unless it was a divide by zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.mlu_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.B != 32'd0) begin
                                pend_lo_d = quot;
                                pend_hi_d = rem;
                                pend_ok_d = 1'b1;
                            end else begin
                                pend_ok_d = 1'b0;
                            end
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_MADDU: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_MSUB: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_MSUBU: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            state_d   = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, pending and architectural registers. Reset aborts any
    // operation in flight without committing it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.mlu_res = (bus.mlu_out == 3'd1) ? hi_q :
                         (bus.mlu_out == 3'd2) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed test of mdu_hilo covering mult/div timing, HI/LO
// moves, the read select, ignored requests, abort on reset and, when
// MDU_MADD_EN is defined, multiply-accumulate.
module tb_mdu_hilo;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdu_hilo_if bus ();

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request for one edge, then scrambles the operands to show
    // that they are sampled only on the start edge.
    task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.mlu_op = op;
        bus.A      = a;
        bus.B      = b;
        step();
        bus.start  = 1'b0;
        bus.mlu_op = 5'd0;
        bus.A      = $urandom;
        bus.B      = $urandom;
    endtask

    // Expects busy for n more cycles with HI/LO holding their old values.
    task automatic check_busy(input string tag, input int n, input logic [31:0] hi_old, input logic [31:0] lo_old);
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            check_output({tag, "_hi_hold"}, bus.HI, hi_old);
            check_output({tag, "_lo_hold"}, bus.LO, lo_old);
            step();
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mlu_op  = 5'd0;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        bus.mlu_out = 3'd0;
        step();
        step();
        check_output("rst_hi", bus.HI, 32'd0);
        check_output("rst_lo", bus.LO, 32'd0);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        step();

        // signed mult: -1 * 2
        apply_stimulus(5'd1, 32'hFFFFFFFF, 32'd2);
        check_busy("mult", 5, 32'd0, 32'd0);
        check_output("mult_done_busy", {31'd0, bus.busy}, 32'd0);
        check_output("mult_hi", bus.HI, 32'hFFFFFFFF);
        check_output("mult_lo", bus.LO, 32'hFFFFFFFE);
        bus.mlu_out = 3'd2;
        #1;
        check_output("mult_res_lo", bus.mlu_res, 32'hFFFFFFFE);

        // unsigned mult: 0xFFFFFFFF * 2
        apply_stimulus(5'd2, 32'hFFFFFFFF, 32'd2);
        check_busy("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        check_output("multu_hi", bus.HI, 32'h00000001);
        check_output("multu_lo", bus.LO, 32'hFFFFFFFE);

        // signed div: -7 / 2 -> q=-3, r=-1
        apply_stimulus(5'd3, 32'hFFFFFFF9, 32'd2);
        check_busy("div", 10, 32'h00000001, 32'hFFFFFFFE);
        check_output("div_done_busy", {31'd0, bus.busy}, 32'd0);
        check_output("div_hi", bus.HI, 32'hFFFFFFFF);
        check_output("div_lo", bus.LO, 32'hFFFFFFFD);

        // divu by zero: full latency, no update
        apply_stimulus(5'd4, 32'd7, 32'd0);
        check_busy("divu0", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_output("divu0_busy", {31'd0, bus.busy}, 32'd0);
        check_output("divu0_hi", bus.HI, 32'hFFFFFFFF);
        check_output("divu0_lo", bus.LO, 32'hFFFFFFFD);

        // signed overflow case
        apply_stimulus(5'd3, 32'h80000000, 32'hFFFFFFFF);
        check_busy("divovf", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_output("divovf_hi", bus.HI, 32'h00000000);
        check_output("divovf_lo", bus.LO, 32'h80000000);

        // unsigned div: 100 / 7 -> q=14, r=2
        apply_stimulus(5'd4, 32'd100, 32'd7);
        check_busy("divu", 10, 32'h00000000, 32'h80000000);
        check_output("divu_hi", bus.HI, 32'd2);
        check_output("divu_lo", bus.LO, 32'd14);

        // mthi / mtlo and the read select
        apply_stimulus(5'd5, 32'h12345678, 32'd0);
        check_output("mthi_hi", bus.HI, 32'h12345678);
        check_output("mthi_busy", {31'd0, bus.busy}, 32'd0);
        apply_stimulus(5'd6, 32'hCAFEF00D, 32'd0);
        check_output("mtlo_lo", bus.LO, 32'hCAFEF00D);
        check_output("mtlo_hi", bus.HI, 32'h12345678);
        bus.mlu_out = 3'd1;
        #1;
        check_output("res_sel_hi", bus.mlu_res, 32'h12345678);
        bus.mlu_out = 3'd2;
        #1;
        check_output("res_sel_lo", bus.mlu_res, 32'hCAFEF00D);
        bus.mlu_out = 3'd0;
        #1;
        check_output("res_sel_0", bus.mlu_res, 32'd0);
        bus.mlu_out = 3'd3;
        #1;
        check_output("res_sel_3", bus.mlu_res, 32'd0);

        // op 0 and unused codes have no effect
        apply_stimulus(5'd0, 32'h11111111, 32'h22222222);
        check_output("op0_busy", {31'd0, bus.busy}, 32'd0);
        check_output("op0_hi", bus.HI, 32'h12345678);
        check_output("op0_lo", bus.LO, 32'hCAFEF00D);
`ifndef MDU_MADD_EN
        apply_stimulus(5'd7, 32'h11111111, 32'h22222222);
        check_output("op7_busy", {31'd0, bus.busy}, 32'd0);
        check_output("op7_lo", bus.LO, 32'hCAFEF00D);
`endif
        apply_stimulus(5'd20, 32'h33333333, 32'h44444444);
        check_output("op20_busy", {31'd0, bus.busy}, 32'd0);
        check_output("op20_hi", bus.HI, 32'h12345678);

        // start while busy is ignored
        apply_stimulus(5'd1, 32'd3, 32'd4);
        check_output("ign_busy0", {31'd0, bus.busy}, 32'd1);
        bus.start  = 1'b1;
        bus.mlu_op = 5'd6;
        bus.A      = 32'h0000DEAD;
        step();
        bus.start  = 1'b0;
        bus.mlu_op = 5'd0;
        check_busy("ign", 4, 32'h12345678, 32'hCAFEF00D);
        check_output("ign_done_busy", {31'd0, bus.busy}, 32'd0);
        check_output("ign_hi", bus.HI, 32'd0);
        check_output("ign_lo", bus.LO, 32'd12);

        // reset in the middle of a divide
        apply_stimulus(5'd5, 32'd5, 32'd0);
        check_output("abort_pre_hi", bus.HI, 32'd5);
        apply_stimulus(5'd3, 32'd100, 32'd7);
        step();
        step();
        step();
        check_output("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort_hi", bus.HI, 32'd0);
        check_output("abort_lo", bus.LO, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check_output("abort_late_busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort_late_hi", bus.HI, 32'd0);
        check_output("abort_late_lo", bus.LO, 32'd0);

`ifdef MDU_MADD_EN
        // multiply-accumulate carries from LO into HI
        apply_stimulus(5'd5, 32'd0, 32'd0);
        apply_stimulus(5'd6, 32'hFFFFFFFF, 32'd0);
        apply_stimulus(5'd7, 32'd1, 32'd1);
        check_busy("madd", 5, 32'd0, 32'hFFFFFFFF);
        check_output("madd_hi", bus.HI, 32'd1);
        check_output("madd_lo", bus.LO, 32'd0);
        apply_stimulus(5'd9, 32'd1, 32'd1);
        check_busy("msub", 5, 32'd1, 32'd0);
        check_output("msub_hi", bus.HI, 32'd0);
        check_output("msub_lo", bus.LO, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
